// File: rtl/aes_enc_core.sv
// Iterative AES-128/192/256 block encryption, one round per clock.
// Round keys are read combinationally from the upstream key-expansion store.
module aes_enc_core (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   aes_mode,
    input  logic         key_rdy,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic [3:0]   rkey_addr,
    input  logic [127:0] rkey,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t       state_r;
    logic [127:0] st_r;
    logic [3:0]   rnd_r;
    logic [3:0]   nr_r;
    logic         out_valid_r;
    logic         busy_r;

    logic [127:0] sb_s;
    logic [127:0] sr_s;
    logic [127:0] mc_s;
    logic [127:0] round_s;
    logic [3:0]   mode_nr_s;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ aa;
            end else begin
                p = p;
            end
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box = affine transform of the multiplicative inverse, inverse taken as x^254.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        a0 = w[31:24];
        a1 = w[23:16];
        a2 = w[15:8];
        a3 = w[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // State byte k sits at bits [127-8k -: 8]; row = k%4, column = k/4.
    for (genvar k = 0; k < 16; k++) begin : g_sbox
        assign sb_s[127-8*k -: 8] = sbox(st_r[127-8*k -: 8]);
    end

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign sr_s[127-8*(4*c+r) -: 8] = sb_s[127-8*(4*((c+r)%4)+r) -: 8];
        end
        assign mc_s[127-32*c -: 32] = mix_col(sr_s[127-32*c -: 32]);
    end

    // Round result: final round skips MixColumns.
    always_comb begin
        round_s = 128'h0;
        if (rnd_r == nr_r) begin
            round_s = sr_s ^ rkey;
        end else begin
            round_s = mc_s ^ rkey;
        end
    end

    // Round count from the requested key length.
    always_comb begin
        mode_nr_s = 4'd10;
        case (aes_mode)
            2'b10:   mode_nr_s = 4'd12;
            2'b11:   mode_nr_s = 4'd14;
            default: mode_nr_s = 4'd10;
        endcase
    end

    // Control FSM and AES state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            st_r        <= 128'h0;
            rnd_r       <= 4'd0;
            nr_r        <= 4'd10;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && key_rdy) begin
                        st_r    <= in_data ^ rkey;
                        nr_r    <= mode_nr_s;
                        rnd_r   <= 4'd1;
                        busy_r  <= 1'b1;
                        state_r <= ROUND;
                    end
                end
                ROUND: begin
                    st_r <= round_s;
                    if (rnd_r == nr_r) begin
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        rnd_r <= rnd_r + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        rnd_r       <= 4'd0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    rnd_r       <= 4'd0;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (state_r == IDLE) && key_rdy;
    assign rkey_addr = rnd_r;
    assign out_valid = out_valid_r;
    assign out_data  = st_r;
    assign busy      = busy_r;
endmodule

// File: tb/tb_aes_enc_core.sv
// Bench for aes_enc_core: acts as the round-key store and compares against a
// table-driven AES reference model (log/antilog GF arithmetic, FIPS key schedule).
module tb_aes_enc_core;
    logic         clk = 1'b0;
    logic         reset, key_rdy, in_valid, in_ready, out_valid, out_ready, busy;
    logic [1:0]   aes_mode;
    logic [127:0] in_data, rkey, out_data;
    logic [3:0]   rkey_addr;

    logic [127:0] rk_mem [16];
    logic [7:0]   ex_t [256];
    logic [7:0]   lg_t [256];
    logic [7:0]   sb_t [256];
    int           n_cmp = 0;
    int           n_err = 0;

    localparam logic [127:0] PT_A   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    always #5 clk = ~clk;
    assign rkey = rk_mem[rkey_addr];

    aes_enc_core dut (
        .clk(clk), .reset(reset), .aes_mode(aes_mode), .key_rdy(key_rdy),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .rkey_addr(rkey_addr), .rkey(rkey), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mul2(input logic [7:0] b);
        return b[7] ? ({b[6:0], 1'b0} ^ 8'h1b) : {b[6:0], 1'b0};
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'h00 || b == 8'h00) return 8'h00;
        return ex_t[(int'(lg_t[a]) + int'(lg_t[b])) % 255];
    endfunction

    task automatic build_tables();
        logic [7:0] x, inv, c, b;
        x = 8'h01;
        c = 8'h63;
        lg_t[0] = 8'h00;
        for (int i = 0; i < 255; i++) begin
            ex_t[i] = x;
            lg_t[x] = 8'(i);
            x = x ^ mul2(x);
        end
        ex_t[255] = 8'h01;
        for (int v = 0; v < 256; v++) begin
            inv = (v == 0) ? 8'h00 : ex_t[(255 - int'(lg_t[v])) % 255];
            for (int k = 0; k < 8; k++)
                b[k] = inv[k] ^ inv[(k+4)%8] ^ inv[(k+5)%8] ^ inv[(k+6)%8] ^ inv[(k+7)%8] ^ c[k];
            sb_t[v] = b;
        end
    endtask

    function automatic int mode_nr(input logic [1:0] m);
        case (m)
            2'b10:   return 12;
            2'b11:   return 14;
            default: return 10;
        endcase
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sb_t[w[31:24]], sb_t[w[23:16]], sb_t[w[15:8]], sb_t[w[7:0]]};
    endfunction

    task automatic expand_key(input logic [255:0] key, input int nk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rcon;
        int nr, tot;
        nr = nk + 6;
        tot = 4 * (nr + 1);
        rcon = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < tot; i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = mul2(rcon);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++)
            rk_mem[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
    endtask

    function automatic logic [127:0] ref_enc(input logic [127:0] pt, input int nr);
        logic [7:0] s [4][4];
        logic [7:0] t [4][4];
        logic [127:0] res;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = pt[127-8*(4*c+r) -: 8] ^ rk_mem[0][127-8*(4*c+r) -: 8];
        for (int rd = 1; rd <= nr; rd++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[r][c] = sb_t[s[r][(c+r)%4]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) begin
                    if (rd < nr)
                        s[r][c] = gmul(8'h02, t[r][c]) ^ gmul(8'h03, t[(r+1)%4][c])
                                ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
                    else
                        s[r][c] = t[r][c];
                    s[r][c] = s[r][c] ^ rk_mem[rd][127-8*(4*c+r) -: 8];
                end
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                res[127-8*(4*c+r) -: 8] = s[r][c];
        return res;
    endfunction

    task automatic wait_valid(input string tag, input int limit);
        int cyc;
        cyc = 0;
        while (!out_valid && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
        if (!out_valid) check({tag, " timeout"}, 128'(out_valid), 128'h1);
    endtask

    // Present one block with out_ready high, follow rkey_addr and latency, check result.
    task automatic run_block(input logic [1:0] mode, input logic [127:0] pt,
                             input logic [127:0] exp, input string tag);
        int nr, lat;
        nr = mode_nr(mode);
        @(negedge clk);
        aes_mode = mode; in_data = pt; in_valid = 1'b1; key_rdy = 1'b1; out_ready = 1'b1;
        #1;
        check({tag, " idle_ready"}, 128'(in_ready), 128'h1);
        check({tag, " addr0"}, 128'(rkey_addr), 128'h0);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
        aes_mode = 2'($urandom());
        key_rdy  = 1'($urandom());
        lat = 1;
        while (!out_valid && lat <= nr + 4) begin
            check({tag, " rkey_addr"}, 128'(rkey_addr), 128'(lat));
            check({tag, " busy_ready"}, 128'({busy, in_ready}), 128'(2'b10));
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 128'(lat), 128'(nr + 1));
        check({tag, " data"}, out_data, exp);
        @(negedge clk);
        check({tag, " handoff"}, 128'({out_valid, busy}), 128'h0);
        key_rdy = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] key;
        logic [127:0] pt1, pt2, exp1;
        logic [1:0]   m;
        logic         seen;

        reset = 1'b1; key_rdy = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        aes_mode = 2'b00; in_data = 128'h0;
        build_tables();
        expand_key(KEY128, 4);
        repeat (2) @(negedge clk);
        check("rst busy", 128'(busy), 128'h0);
        check("rst out_valid", 128'(out_valid), 128'h0);
        check("rst rkey_addr", 128'(rkey_addr), 128'h0);
        check("rst out_data", out_data, 128'h0);
        check("rst in_ready_lo", 128'(in_ready), 128'h0);
        reset = 1'b0;
        key_rdy = 1'b1;
        #1 check("rst in_ready_hi", 128'(in_ready), 128'h1);

        // Known-answer vectors.
        run_block(2'b01, PT_A, CT128, "kat128");
        expand_key({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 6);
        run_block(2'b10, PT_A, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, "kat192");
        expand_key(256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 8);
        run_block(2'b11, 128'h6bc1bee22e409f96e93d7e117393172a,
                  128'hf3eed1bdb5d2a03c064b5a7e3db181f8, "kat256");

        // Gating on key_rdy.
        expand_key(KEY128, 4);
        @(negedge clk);
        key_rdy = 1'b0; in_valid = 1'b1; in_data = PT_A; aes_mode = 2'b01; out_ready = 1'b1;
        repeat (5) begin
            #1 check("gate in_ready", 128'(in_ready), 128'h0);
            @(negedge clk);
            check("gate busy", 128'(busy), 128'h0);
        end
        key_rdy = 1'b1;
        #1 check("gate raise", 128'(in_ready), 128'h1);
        @(negedge clk);
        in_valid = 1'b0;
        check("gate accept", 128'(busy), 128'h1);
        wait_valid("gate", 30);
        check("gate data", out_data, CT128);
        @(negedge clk);

        // Backpressure: hold the result, refuse a second block, then take it.
        for (int i = 0; i < 8; i++) key[255-32*i -: 32] = $urandom();
        m = 2'($urandom_range(1, 3));
        expand_key(key, mode_nr(m) - 6);
        pt1 = {$urandom(), $urandom(), $urandom(), $urandom()};
        pt2 = {$urandom(), $urandom(), $urandom(), $urandom()};
        exp1 = ref_enc(pt1, mode_nr(m));
        @(negedge clk);
        in_valid = 1'b1; in_data = pt1; aes_mode = m; out_ready = 1'b0; key_rdy = 1'b1;
        @(negedge clk);
        in_data = pt2;
        wait_valid("bp first", 30);
        for (int i = 0; i < 20; i++) begin
            check("bp hold data", out_data, exp1);
            check("bp hold flags", 128'({out_valid, busy, in_ready}), 128'(3'b110));
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp release", 128'({out_valid, busy, in_ready}), 128'(3'b001));
        @(negedge clk);
        in_valid = 1'b0;
        check("bp second accept", 128'(busy), 128'h1);
        wait_valid("bp second", 30);
        check("bp second data", out_data, ref_enc(pt2, mode_nr(m)));
        @(negedge clk);

        // Reset in the middle of a block.
        expand_key(KEY128, 4);
        @(negedge clk);
        in_valid = 1'b1; in_data = PT_A; aes_mode = 2'b01; key_rdy = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 20 && rkey_addr != 4'd5; i++) @(negedge clk);
        check("mid rnd5", 128'(rkey_addr), 128'h5);
        reset = 1'b1;
        @(negedge clk);
        check("mid rst flags", 128'({busy, out_valid}), 128'h0);
        check("mid rst addr", 128'(rkey_addr), 128'h0);
        check("mid rst data", out_data, 128'h0);
        reset = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        check("mid no out_valid", 128'(seen), 128'h0);
        run_block(2'b01, PT_A, CT128, "post_rst");

        // Randomized blocks against the reference model.
        for (int n = 0; n < 24; n++) begin
            for (int i = 0; i < 8; i++) key[255-32*i -: 32] = $urandom();
            m = 2'($urandom());
            expand_key(key, mode_nr(m) - 6);
            pt1 = {$urandom(), $urandom(), $urandom(), $urandom()};
            run_block(m, pt1, ref_enc(pt1, mode_nr(m)), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/aes_enc_core.md
# aes_enc_core

Iterative AES block-encryption engine that sits directly downstream of `key_exp_outer`. It performs one AES round per clock. It reads round keys from the key-expansion store through that block's `rkey_addr`/`rkey` read port, and gates acceptance on its `rdy`. It takes 128-bit plaintext blocks through a valid/ready input and returns ciphertext through a valid/ready output. Key length (AES-128/192/256) is selected per block.

## Interface
Parameters: none.

- `clk` in 1: single clock; all state changes on posedge.
- `reset` in 1: synchronous, active-high; one clock, synchronous reset, active-high.
- `aes_mode` in 2: key length; 2'b01 = AES-128 (Nr=10), 2'b10 = AES-192 (Nr=12), 2'b11 = AES-256 (Nr=14), 2'b00 treated as AES-128. Sampled only at block accept.
- `key_rdy` in 1: from key expansion `rdy`; round-key store valid.
- `in_valid` in 1: plaintext block valid.
- `in_ready` out 1: engine can accept a block.
- `in_data` in 128: plaintext; bits [127:120] = state byte 0, column-major per FIPS-197.
- `rkey_addr` out 4: round-key index to key expansion.
- `rkey` in 128: round key at `rkey_addr`, combinational (same-cycle) read.
- `out_valid` out 1: ciphertext valid.
- `out_ready` in 1: downstream accepts ciphertext.
- `out_data` out 128: ciphertext, same byte order as `in_data`.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- Internal registers:
  - `st[127:0]` holds the AES state.
  - `rnd[3:0]` is the round counter and drives `rkey_addr` directly (registered).
  - `nr[3:0]` is latched from `aes_mode` at accept.
- FSM states: IDLE, ROUND, DONE.
- IDLE: `rnd`=0, so `rkey` = key 0. `in_ready` = `key_rdy`. On `in_valid && in_ready`:
  - `st <= in_data ^ rkey`
  - `nr` latched
  - `rnd <= 1`
  - go to ROUND.
- ROUND, `rnd < nr`: `st <= MixColumns(ShiftRows(SubBytes(st))) ^ rkey`, `rnd <= rnd+1`.
- ROUND, `rnd == nr`: final round without MixColumns; `st <= ShiftRows(SubBytes(st)) ^ rkey`, go to DONE.
- DONE: `out_valid`=1 and `out_data`=`st`, held stable until `out_ready`. On `out_ready`, `rnd <= 0` and go to IDLE.
- SubBytes uses 16 instances of the team's combinational S-box. MixColumns uses xtime over GF(2^8) with polynomial 0x11B. All arithmetic is byte-wise XOR; no carries.
- `in_ready`=0 in ROUND and DONE. No input buffering: at most one block is in flight.
- `key_rdy` falling mid-block is ignored. The owner of the key store must not rewrite keys while `busy`=1.
- `aes_mode` changes mid-block have no effect until the next accept.

## Timing
- Reset values:
  - state = IDLE, `rnd` = 0, so `rkey_addr` = 0.
  - `st` = 0, `out_data` = 0.
  - `out_valid` = 0, `busy` = 0.
  - `in_ready` = `key_rdy` (combinational from IDLE).
- Accept at edge T0. Rounds 1..Nr execute at edges T1..TNr. `out_valid` rises after edge TNr.
- Input-accept to `out_valid` latency: Nr+1 cycles, i.e. 11 for AES-128, 13 for AES-192, 15 for AES-256.
- `rkey_addr` equals the round being computed in each ROUND cycle: 1..Nr.
- Handshake completes on the cycle `out_valid && out_ready` are both high. The engine is in IDLE the next cycle, so `in_ready` can be 1 one cycle after output handoff.
- Throughput, with `out_ready` held high: Nr+2 cycles per block.
- Reset asserted in any state, including mid-ROUND or in DONE with `out_valid`=1: next cycle is IDLE with all reset values. The in-flight block is discarded, and no `out_valid` pulse occurs for it.
- `in_valid` while `key_rdy`=0: no accept; `in_ready`=0.

## Test plan
- AES-128: key 000102030405060708090a0b0c0d0e0f, mode 01, pt 00112233445566778899aabbccddeeff -> `out_data` 69c4e0d86a7b0430d8cdb78070b4c55a; `out_valid` exactly 11 cycles after accept; `rkey_addr` sequence 0,1..10.
- AES-192: key 000102…1617, mode 10, same pt -> dda97ca4864cdfe06eaf70a0ec0d7191, latency 13.
- AES-256: key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, mode 11, pt 6bc1bee22e409f96e93d7e117393172a -> f3eed1bdb5d2a03c064b5a7e3db181f8, latency 15.
- Backpressure: hold `out_ready`=0 for 20 cycles after `out_valid` -> `out_data` stable, `in_ready`=0, and a second `in_valid` is not accepted. Release -> IDLE next cycle, then the second block is accepted.
- Gating: `in_valid`=1 with `key_rdy`=0 -> `in_ready`=0 and no accept. Raise `key_rdy` -> accept on that cycle.
- Reset mid-round at `rnd`=5 -> next cycle `busy`=0, `rkey_addr`=0, `out_valid`=0. A following AES-128 vector still gives 69c4e0d8….
